pc_gen: RTL and testbench

- Parametrised next-generation program counter unit for the fetch stage.
- Holds the PC register and selects among sequential, PC-relative and register-indirect (JALR) targets.
- Supports a pipeline stall, a registered fetch valid/ready handshake toward instruction memory, and a sticky misaligned-target fault state.
- Sits between the control/execute redirect logic and the instruction memory address port.

---
 rtl/pc_gen.sv | 102 ++++++++++
 tb/tb_pc_gen.sv | 122 ++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch-stage program counter: sequential / PC-relative / JALR target select,
// fetch handshake toward instruction memory, and a sticky misaligned-target halt.
module pc_gen #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    STEP         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Redirect,
  input  logic [1:0]            PCSrc,
  input  logic [DATA_WIDTH-1:0] BranchPC,
  input  logic [DATA_WIDTH-1:0] ImmExt,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic                  Stall,
  input  logic                  FetchReady,
  output logic                  FetchValid,
  output logic [DATA_WIDTH-1:0] PCOut,
  output logic [DATA_WIDTH-1:0] PCPlusStep,
  output logic                  MisalignErr,
  output logic [DATA_WIDTH-1:0] FaultPC
);

  // state | meaning
  // BOOT  | first cycle after reset, no fetch issued
  // RUN   | fetching, PC advances on handshake or redirect
  // HALT  | misaligned target seen, frozen until reset
  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  localparam logic [DATA_WIDTH-1:0] STEP_V   = DATA_WIDTH'(STEP);
  localparam logic [DATA_WIDTH-1:0] BIT0_CLR = {{(DATA_WIDTH-1){1'b1}}, 1'b0};

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] fault_pc_q, fault_pc_d;
  logic                  err_q, err_d;
  logic                  fetch_valid_q, fetch_valid_d;
  logic [DATA_WIDTH-1:0] pc_plus_step;
  logic [DATA_WIDTH-1:0] target;

  assign pc_plus_step = pc_q + STEP_V;

  always_comb begin
    target = pc_plus_step;
    case (PCSrc)
      2'b01:   target = BranchPC + ImmExt;
      2'b10:   target = ALUResult & BIT0_CLR;
      default: target = pc_plus_step;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    err_d      = err_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (Redirect) begin
          if (target[1:0] != 2'b00) begin
            fault_pc_d = target;
            err_d      = 1'b1;
            state_d    = HALT;
          end else begin
            pc_d = target;
          end
        end else if (!Stall && fetch_valid_q && FetchReady) begin
          pc_d = pc_plus_step;
        end
      end
      HALT: state_d = HALT;
      default: state_d = BOOT;
    endcase
    fetch_valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      fault_pc_q    <= '0;
      err_q         <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fault_pc_q    <= fault_pc_d;
      err_q         <= err_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  assign FetchValid  = fetch_valid_q;
  assign PCOut       = pc_q;
  assign PCPlusStep  = pc_plus_step;
  assign MisalignErr = err_q;
  assign FaultPC     = fault_pc_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with RESET_VECTOR=0x100.
module tb_pc_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic        Redirect;
  logic [1:0]  PCSrc;
  logic [31:0] BranchPC;
  logic [31:0] ImmExt;
  logic [31:0] ALUResult;
  logic        Stall;
  logic        FetchReady;
  logic        FetchValid;
  logic [31:0] PCOut;
  logic [31:0] PCPlusStep;
  logic        MisalignErr;
  logic [31:0] FaultPC;

  int n_cmp = 0;
  int n_err = 0;

  pc_gen #(.DATA_WIDTH(32), .RESET_VECTOR(32'h0000_0100), .STEP(4)) dut (
    .clk(clk), .rst(rst), .Redirect(Redirect), .PCSrc(PCSrc),
    .BranchPC(BranchPC), .ImmExt(ImmExt), .ALUResult(ALUResult),
    .Stall(Stall), .FetchReady(FetchReady), .FetchValid(FetchValid),
    .PCOut(PCOut), .PCPlusStep(PCPlusStep), .MisalignErr(MisalignErr),
    .FaultPC(FaultPC)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic fv,
                         input logic err, input logic [31:0] fpc);
    chk({tag, ".pc"},  PCOut, pc);
    chk({tag, ".pps"}, PCPlusStep, pc + 32'd4);
    chk({tag, ".fv"},  {31'd0, FetchValid}, {31'd0, fv});
    chk({tag, ".err"}, {31'd0, MisalignErr}, {31'd0, err});
    chk({tag, ".fpc"}, FaultPC, fpc);
  endtask

  initial begin
    rst = 1'b0; Redirect = 1'b0; PCSrc = 2'b00; BranchPC = '0; ImmExt = '0;
    ALUResult = '0; Stall = 1'b0; FetchReady = 1'b1;
    tick(); tick();
    chk_all("reset", 32'h100, 1'b0, 1'b0, 32'h0);

    // BOOT ignores a redirect that would otherwise go to 0x3000
    rst = 1'b1; Redirect = 1'b1; PCSrc = 2'b01; BranchPC = 32'h1000; ImmExt = 32'h2000;
    tick();
    chk_all("boot", 32'h100, 1'b1, 1'b0, 32'h0);
    Redirect = 1'b0;
    tick(); chk_all("seq1", 32'h104, 1'b1, 1'b0, 32'h0);
    tick(); chk_all("seq2", 32'h108, 1'b1, 1'b0, 32'h0);

    FetchReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_all("notready", 32'h108, 1'b1, 1'b0, 32'h0);
    end
    FetchReady = 1'b1;
    tick(); chk_all("ready", 32'h10C, 1'b1, 1'b0, 32'h0);

    Redirect = 1'b1; PCSrc = 2'b01; BranchPC = 32'h104; ImmExt = 32'hFFFF_FFF8; Stall = 1'b1;
    tick(); chk_all("br_stall", 32'h0FC, 1'b1, 1'b0, 32'h0);
    Redirect = 1'b0;
    tick(); chk_all("stall", 32'h0FC, 1'b1, 1'b0, 32'h0);

    Stall = 1'b0; FetchReady = 1'b0; Redirect = 1'b1; PCSrc = 2'b00;
    tick(); chk_all("force00", 32'h100, 1'b1, 1'b0, 32'h0);
    PCSrc = 2'b11;
    tick(); chk_all("force11", 32'h104, 1'b1, 1'b0, 32'h0);

    FetchReady = 1'b1; PCSrc = 2'b10; ALUResult = 32'h2001;
    tick(); chk_all("jalr", 32'h2000, 1'b1, 1'b0, 32'h0);
    ALUResult = 32'hFFFF_FFFC;
    tick(); chk_all("jalr_top", 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0);
    Redirect = 1'b0;
    tick(); chk_all("wrap", 32'h0, 1'b1, 1'b0, 32'h0);

    Redirect = 1'b1; PCSrc = 2'b10; ALUResult = 32'h2002;
    tick(); chk_all("fault", 32'h0, 1'b0, 1'b1, 32'h2002);

    for (int i = 0; i < 8; i++) begin
      Redirect = 1'($urandom); PCSrc = 2'($urandom); BranchPC = $urandom;
      ImmExt = $urandom; ALUResult = $urandom; Stall = 1'($urandom);
      FetchReady = 1'($urandom);
      tick(); chk_all("halt", 32'h0, 1'b0, 1'b1, 32'h2002);
    end

    // reset from HALT, with a redirect pending
    rst = 1'b0; Redirect = 1'b1; PCSrc = 2'b01; BranchPC = 32'h40; ImmExt = 32'h0;
    tick(); chk_all("rst_halt", 32'h100, 1'b0, 1'b0, 32'h0);

    rst = 1'b1; Redirect = 1'b0; Stall = 1'b0; FetchReady = 1'b1;
    tick(); chk_all("reboot", 32'h100, 1'b1, 1'b0, 32'h0);
    tick(); chk_all("reseq", 32'h104, 1'b1, 1'b0, 32'h0);
    Stall = 1'b1;
    tick(); chk_all("stall2", 32'h104, 1'b1, 1'b0, 32'h0);
    rst = 1'b0;
    tick(); chk_all("rst_stall", 32'h100, 1'b0, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
